// File: rtl/mul_sched.sv
// Two-requester scheduler for one shared combinational multiplier; one op in flight.
// Optional round-robin grant when MUL_SCHED_RR_EN is defined, otherwise requester 0 has fixed priority.
package mul_sched_pkg;
   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3
   } alu_t;
endpackage

module mul_sched
   import mul_sched_pkg::*;
#(
   parameter int MUL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_rs1,
   input  logic [31:0] req0_rs2,
   input  alu_t        req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_rs1,
   input  logic [31:0] req1_rs2,
   input  alu_t        req1_op,
   output logic [31:0] m_rs1,
   output logic [31:0] m_rs2,
   output alu_t        m_op,
   input  logic [31:0] m_result,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp_data,
   input  logic        flush0
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] rs1_q, rs1_d;
   logic [31:0] rs2_q, rs2_d;
   alu_t        op_q, op_d;
   logic        owner_q, owner_d;
   logic [31:0] data_q, data_d;
`ifdef MUL_SCHED_RR_EN
   logic        prio_q, prio_d;
`endif

   logic v0, v1, gnt0, gnt1, idle, hs0, hs1, flush_own;

   // A flushed requester 0 is treated as not requesting, so requester 1 may take the slot.
   always_comb begin
      v0 = req0_valid & ~flush0;
      v1 = req1_valid;
`ifdef MUL_SCHED_RR_EN
      gnt1 = v1 & (~v0 | prio_q);
`else
      gnt1 = v1 & ~v0;
`endif
      gnt0 = v0 & ~gnt1;
      idle = (state_q == IDLE) & ~reset;
      req0_ready = idle & gnt0;
      req1_ready = idle & gnt1;
      hs0 = req0_valid & req0_ready;
      hs1 = req1_valid & req1_ready;
      flush_own = flush0 & ~owner_q;
      rsp0_valid = ~reset & (state_q == DONE) & ~owner_q & ~flush0;
      rsp1_valid = ~reset & (state_q == DONE) & owner_q;
      rsp_data = data_q;
      m_rs1 = rs1_q;
      m_rs2 = rs2_q;
      m_op = reset ? MUL : op_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      op_d    = op_q;
      owner_d = owner_q;
      data_d  = data_q;
`ifdef MUL_SCHED_RR_EN
      prio_d  = prio_q;
`endif
      case (state_q)
         IDLE: begin
            if (hs0 | hs1) begin
               rs1_d   = hs1 ? req1_rs1 : req0_rs1;
               rs2_d   = hs1 ? req1_rs2 : req0_rs2;
               op_d    = hs1 ? req1_op  : req0_op;
               owner_d = hs1;
               cnt_d   = 2'(MUL_CYCLES - 1);
               state_d = BUSY;
`ifdef MUL_SCHED_RR_EN
               prio_d  = hs0;
`endif
            end
         end
         BUSY: begin
            if (flush_own) begin
               state_d = IDLE;
            end else if (cnt_q == 2'd0) begin
               data_d  = m_result;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         DONE: begin
            if (flush_own || (owner_q ? rsp1_ready : rsp0_ready))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         rs1_q   <= 32'd0;
         rs2_q   <= 32'd0;
         op_q    <= MUL;
         owner_q <= 1'b0;
         data_q  <= 32'd0;
`ifdef MUL_SCHED_RR_EN
         prio_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         op_q    <= op_d;
         owner_q <= owner_d;
         data_q  <= data_d;
`ifdef MUL_SCHED_RR_EN
         prio_q  <= prio_d;
`endif
      end
   end

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched: one instance at MUL_CYCLES=1 (a_*) and one at MUL_CYCLES=3 (b_*).
module tb_mul_sched;
   import mul_sched_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready, flush0;
   logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
   alu_t        req0_op, req1_op;

   logic        a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid;
   logic [31:0] a_m_rs1, a_m_rs2, a_m_result, a_rsp_data;
   alu_t        a_m_op;
   logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
   logic [31:0] b_m_rs1, b_m_rs2, b_m_result, b_rsp_data;
   alu_t        b_m_op;

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External multiplier; illegal ops return a^b so the pass-through is observable.
   function automatic logic [31:0] mmodel(input logic [31:0] a, input logic [31:0] b, input alu_t op);
      logic signed [63:0] sa, sb, sp;
      logic [63:0] ua, ub, up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         MUL:     begin up = ua * ub; return up[31:0]; end
         MULH:    begin sp = sa * sb; return sp[63:32]; end
         MULHSU:  begin sp = sa * $signed(ub); return sp[63:32]; end
         MULHU:   begin up = ua * ub; return up[63:32]; end
         default: return a ^ b;
      endcase
   endfunction

   assign a_m_result = mmodel(a_m_rs1, a_m_rs2, a_m_op);
   assign b_m_result = mmodel(b_m_rs1, b_m_rs2, b_m_op);

   mul_sched #(.MUL_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_op(req1_op),
      .m_rs1(a_m_rs1), .m_rs2(a_m_rs2), .m_op(a_m_op), .m_result(a_m_result),
      .rsp0_valid(a_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(a_rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(a_rsp_data), .flush0(flush0));

   mul_sched #(.MUL_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_op(req1_op),
      .m_rs1(b_m_rs1), .m_rs2(b_m_rs2), .m_op(b_m_op), .m_result(b_m_result),
      .rsp0_valid(b_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(b_rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(b_rsp_data), .flush0(flush0));

   typedef struct {
      bit          who;
      alu_t        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t tbl[7];

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic sel(input int which);
      case (which)
         0: return a_req0_ready;
         1: return a_req1_ready;
         2: return a_rsp0_valid;
         3: return a_rsp1_valid;
         4: return b_req0_ready;
         5: return b_req1_ready;
         6: return b_rsp0_valid;
         default: return b_rsp1_valid;
      endcase
   endfunction

   // Samples 1 ns into each cycle until the selected signal rises or the budget runs out.
   task automatic wait_sig(input int which, input string nm, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (sel(which)) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout waiting, got 0, expected 1", nm);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      flush0 = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int tacc;
      bit ok;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      if (!v.who) begin
         req0_valid = 1'b1; req0_rs1 = v.a; req0_rs2 = v.b; req0_op = v.op;
      end else begin
         req1_valid = 1'b1; req1_rs1 = v.a; req1_rs2 = v.b; req1_op = v.op;
      end
      wait_sig(v.who ? 1 : 0, {v.name, "_accept"}, ok);
      tacc = cyc;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (!ok) return;
      wait_sig(v.who ? 3 : 2, {v.name, "_rsp"}, ok);
      if (ok) begin
         chk({v.name, "_latency"}, 32'(cyc - tacc), 32'd2);
         chk({v.name, "_data"}, a_rsp_data, v.exp);
         chk({v.name, "_other_valid"}, 32'(v.who ? a_rsp0_valid : a_rsp1_valid), 32'd0);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int ng, last, t1acc, trsp;
      bit seen0, seen1;
      logic [31:0] held;
      logic [3:0] gexp, gact;

      tbl[0] = '{1'b0, MUL,        32'd7,        32'd6,        32'd42,       "mul_7x6"};
      tbl[1] = '{1'b1, MULHU,      32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max"};
      tbl[2] = '{1'b0, MULH,       32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, "mulh_neg"};
      tbl[3] = '{1'b1, MULHSU,     32'h80000000, 32'h80000000, 32'hC0000000, "mulhsu_min"};
      tbl[4] = '{1'b0, MULH,       32'h80000000, 32'h80000000, 32'h40000000, "mulh_min"};
      tbl[5] = '{1'b1, MUL,        32'h00010000, 32'h00010000, 32'h00000000, "mul_wrap"};
      tbl[6] = '{1'b0, alu_t'(3'd5), 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, "illegal_op"};

      req0_rs1 = 32'd0; req0_rs2 = 32'd0; req0_op = MUL;
      req1_rs1 = 32'd0; req1_rs2 = 32'd0; req1_op = MUL;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1; flush0 = 1'b0;

      // Reset state, with requests pending to show the gating.
      reset = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_op = MULHU; req1_op = MULH;
      tick();
      tick();
      #1;
      chk("rst_req0_ready", 32'(a_req0_ready), 32'd0);
      chk("rst_req1_ready", 32'(a_req1_ready), 32'd0);
      chk("rst_rsp_valids", 32'({a_rsp0_valid, a_rsp1_valid}), 32'd0);
      chk("rst_m_op", 32'(a_m_op), 32'(MUL));
      chk("rst_m_rs1", a_m_rs1, 32'd0);
      chk("rst_rsp_data", a_rsp_data, 32'd0);
      tick();
      reset = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) run_vec(tbl[i]);

      // Both requesters valid continuously: grant order and issue spacing.
      do_reset();
      req0_valid = 1'b1; req0_rs1 = 32'd2; req0_rs2 = 32'd3; req0_op = MUL;
      req1_valid = 1'b1; req1_rs1 = 32'd4; req1_rs2 = 32'd5; req1_op = MUL;
      ng = 0; last = 0; gact = 4'd0;
      for (int i = 0; i < 60 && ng < 4; i++) begin
         #1;
         if (a_req0_ready | a_req1_ready) begin
            chk("grant_exclusive", 32'(a_req0_ready & a_req1_ready), 32'd0);
            gact[ng] = a_req1_ready;
            if (ng > 0) chk("issue_interval", 32'(cyc - last), 32'd3);
            last = cyc;
            ng++;
         end
         tick();
      end
`ifdef MUL_SCHED_RR_EN
      gexp = 4'b1010;
`else
      gexp = 4'b0000;
`endif
      chk("grant_count", 32'(ng), 32'd4);
      chk("grant_order", 32'(gact), 32'(gexp));
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Response held off for 5 cycles.
      do_reset();
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_rs1 = 32'd9; req0_rs2 = 32'd9; req0_op = MUL;
      wait_sig(0, "hold_accept", ok);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_rs1 = 32'd1; req1_rs2 = 32'd1; req1_op = MUL;
      wait_sig(2, "hold_rsp", ok);
      held = a_rsp_data;
      chk("hold_data", held, 32'd81);
      for (int i = 0; i < 5; i++) begin
         chk("hold_stable_data", a_rsp_data, held);
         chk("hold_stable_valid", 32'(a_rsp0_valid), 32'd1);
         chk("hold_no_ready", 32'({a_req0_ready, a_req1_ready}), 32'd0);
         tick();
         #1;
      end
      rsp0_ready = 1'b1;
      tick();
      #1;
      chk("hold_idle_after", 32'(a_req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      repeat (6) tick();

      // Flush in IDLE, flush of an owned op, then flush ignored for requester 1 (MUL_CYCLES=3).
      do_reset();
      req0_valid = 1'b1; req0_rs1 = 32'd7; req0_rs2 = 32'd6; req0_op = MUL;
      flush0 = 1'b1;
      #1;
      chk("flush_idle_ready", 32'({a_req0_ready, b_req0_ready}), 32'd0);
      flush0 = 1'b0;
      wait_sig(4, "flush_accept", ok);
      tick();
      req0_valid = 1'b0;
      flush0 = 1'b1;
      tick();
      flush0 = 1'b0;
      req1_valid = 1'b1; req1_rs1 = 32'd3; req1_rs2 = 32'd5; req1_op = MUL;
      #1;
      t1acc = cyc;
      chk("flush_idle_next", 32'(b_req1_ready), 32'd1);
      chk("flush_no_rsp0", 32'(b_rsp0_valid), 32'd0);
      tick();
      req1_valid = 1'b0;
      flush0 = 1'b1;
      seen0 = 1'b0; seen1 = 1'b0; trsp = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (b_rsp0_valid) seen0 = 1'b1;
         if (b_rsp1_valid && !seen1) begin
            seen1 = 1'b1;
            trsp = cyc;
            chk("flush_req1_data", b_rsp_data, 32'd15);
         end
         tick();
      end
      flush0 = 1'b0;
      chk("flush_rsp0_never", 32'(seen0), 32'd0);
      chk("flush_rsp1_seen", 32'(seen1), 32'd1);
      chk("flush_req1_latency", 32'(trsp - t1acc), 32'd4);

      // Reset while BUSY discards the operation.
      do_reset();
      req0_valid = 1'b1; req0_rs1 = 32'd7; req0_rs2 = 32'd6; req0_op = MUL;
      wait_sig(0, "midrst_accept", ok);
      tick();
      req0_valid = 1'b0;
      reset = 1'b1;
      tick();
      #1;
      chk("midrst_readies", 32'({a_req0_ready, a_req1_ready}), 32'd0);
      chk("midrst_valids", 32'({a_rsp0_valid, a_rsp1_valid}), 32'd0);
      chk("midrst_data", a_rsp_data, 32'd0);
      chk("midrst_m_rs1", a_m_rs1, 32'd0);
      tick();
      reset = 1'b0;
      seen0 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (a_rsp0_valid | a_rsp1_valid) seen0 = 1'b1;
         tick();
      end
      chk("midrst_no_stale", 32'(seen0), 32'd0);
      req1_valid = 1'b1;
      #1;
      chk("midrst_idle", 32'(a_req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
